// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register-file bridge.
//   state_e            : bridge FSM states (IDLE / ACTIVE / COMMIT)
//   addr_valid()       : true when an address falls inside the register space
//   DEFAULT_WORD_SIZE  : default register width in bits
package spi_regs_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic addr_valid(input int unsigned addr, input int unsigned space);
        return addr < space;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// WORD_SIZE x DEPTH register array with a load-all port and a single-entry
// write port. When both fire in the same cycle, the single-entry write wins
// on its entry, so a write landing on the load cycle is not lost.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears all entries)
//   load_i       : copy load_data_i into every entry
//   load_data_i  : flat load image, entry i at [i*WORD_SIZE +: WORD_SIZE]
//   we_i         : write wdata_i into entry waddr_i
//   waddr_i      : write address
//   wdata_i      : write data
//   data_o       : flat view of all entries
module spi_reg_bank #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AW        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic [WORD_SIZE*DEPTH-1:0] load_data_i,
    input  logic                       we_i,
    input  logic [AW-1:0]              waddr_i,
    input  logic [WORD_SIZE-1:0]       wdata_i,
    output logic [WORD_SIZE*DEPTH-1:0] data_o
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (we_i && waddr_i == AW'(i))
                    mem_q[i] <= wdata_i;
                else if (load_i)
                    mem_q[i] <= load_data_i[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign data_o[g*WORD_SIZE +: WORD_SIZE] = mem_q[g];
    end

endmodule

// File: rtl/spi_regfile_bridge.sv
// Transaction-atomic register file between the SPI address/data front end and
// fabric logic. Writes in a transaction are staged and land in rx_arr_o
// together when CS drops; reads in a transaction come from a tx_arr_i
// snapshot taken when CS rises.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   reg_addr_i        : request address
//   write_i           : request is a write (qualified by new_req_i)
//   new_req_i         : one-cycle request strobe
//   write_value_i     : write data
//   read_value_o      : read data, valid one cycle after new_req_i
//   in_transaction_i  : SPI chip-select active
//   tx_arr_i          : live fabric-to-host registers (flat)
//   rx_arr_o          : committed host-to-fabric registers (flat)
//   rx_wr_mask_o      : registers written by the last committed transaction
//   new_rx_o          : one-cycle pulse, high in the cycle rx_arr_o shows new data
//   busy_o            : transaction open or committing
//   err_o             : one-cycle pulse on RO write or out-of-range access
module spi_regfile_bridge
    import spi_regs_pkg::*;
#(
    parameter int unsigned          ADDR_SPACE = 256,
    parameter int unsigned          WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter logic [ADDR_SPACE-1:0] RO_MASK   = '0,
    localparam int unsigned         AW = (ADDR_SPACE > 1) ? $clog2(ADDR_SPACE) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [AW-1:0]                   reg_addr_i,
    input  logic                            write_i,
    input  logic                            new_req_i,
    input  logic [WORD_SIZE-1:0]            write_value_i,
    output logic [WORD_SIZE-1:0]            read_value_o,
    input  logic                            in_transaction_i,
    input  logic [WORD_SIZE*ADDR_SPACE-1:0] tx_arr_i,
    output logic [WORD_SIZE*ADDR_SPACE-1:0] rx_arr_o,
    output logic [ADDR_SPACE-1:0]           rx_wr_mask_o,
    output logic                            new_rx_o,
    output logic                            busy_o,
    output logic                            err_o
);

    // RO mask widened to the full address range so any AW-bit address indexes it.
    localparam logic [(1<<AW)-1:0] RO_FULL = ((1<<AW))'(RO_MASK);

    state_e                          state_q, state_d;
    logic                            start, commit;
    logic                            in_range, ro_hit, req_ok, wr_ok;
    logic [WORD_SIZE-1:0]            rd_word;
    logic [WORD_SIZE-1:0]            read_value_q;
    logic [WORD_SIZE*ADDR_SPACE-1:0] rx_arr_q, staging, snapshot;
    logic [ADDR_SPACE-1:0]           rx_wr_mask_q, stage_mask_q, stage_mask_d;
    logic                            new_rx_q, busy_q, err_q;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE:    if (in_transaction_i) begin state_d = ACTIVE; start = 1'b1; end
            ACTIVE:  if (!in_transaction_i) state_d = COMMIT;
            COMMIT:  begin state_d = IDLE; commit = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    // Requests count on the CS-rise cycle as well as in ACTIVE.
    assign in_range = addr_valid(32'(reg_addr_i), ADDR_SPACE);
    assign ro_hit   = in_range && RO_FULL[reg_addr_i];
    assign req_ok   = new_req_i && (start || state_q == ACTIVE);
    assign wr_ok    = req_ok && write_i && in_range && !ro_hit;

    // On the CS-rise cycle the snapshot is still loading, so read live tx_arr.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (start) rd_word = tx_arr_i[32'(reg_addr_i)*WORD_SIZE +: WORD_SIZE];
            else       rd_word = snapshot[32'(reg_addr_i)*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_comb begin
        stage_mask_d = start ? '0 : stage_mask_q;
        for (int i = 0; i < int'(ADDR_SPACE); i++)
            if (wr_ok && reg_addr_i == AW'(i)) stage_mask_d[i] = 1'b1;
    end

    spi_reg_bank #(.WORD_SIZE(WORD_SIZE), .DEPTH(ADDR_SPACE), .AW(AW)) u_staging (
        .clk(clk), .rst(rst),
        .load_i(start), .load_data_i(rx_arr_q),
        .we_i(wr_ok), .waddr_i(reg_addr_i), .wdata_i(write_value_i),
        .data_o(staging)
    );

    spi_reg_bank #(.WORD_SIZE(WORD_SIZE), .DEPTH(ADDR_SPACE), .AW(AW)) u_snapshot (
        .clk(clk), .rst(rst),
        .load_i(start), .load_data_i(tx_arr_i),
        .we_i(1'b0), .waddr_i('0), .wdata_i('0),
        .data_o(snapshot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            read_value_q <= '0;
            rx_arr_q     <= '0;
            rx_wr_mask_q <= '0;
            stage_mask_q <= '0;
            new_rx_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_mask_q <= stage_mask_d;
            busy_q       <= (state_d != IDLE);
            err_q        <= req_ok && (!in_range || (write_i && ro_hit));
            new_rx_q     <= 1'b0;
            // Out-of-range accesses return zero; in-range writes leave read data alone.
            if (req_ok && (!write_i || !in_range)) read_value_q <= rd_word;
            if (commit && stage_mask_q != '0) begin
                rx_arr_q     <= staging;
                rx_wr_mask_q <= stage_mask_q;
                new_rx_q     <= 1'b1;
            end
        end
    end

    assign read_value_o = read_value_q;
    assign rx_arr_o     = rx_arr_q;
    assign rx_wr_mask_o = rx_wr_mask_q;
    assign new_rx_o     = new_rx_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_spi_regfile_bridge.sv
module tb_spi_regfile_bridge;

    localparam int unsigned AS = 6;
    localparam int unsigned WS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    reg_addr = '0;
    logic          write = 1'b0;
    logic          new_req = 1'b0;
    logic [7:0]    write_value = '0;
    logic [7:0]    read_value;
    logic          in_transaction = 1'b0;
    logic [47:0]   tx_arr = 48'h605040302011;
    logic [47:0]   rx_arr;
    logic [5:0]    rx_wr_mask;
    logic          new_rx, busy, err;

    int checks = 0;
    int failures = 0;

    spi_regfile_bridge #(.ADDR_SPACE(AS), .WORD_SIZE(WS), .RO_MASK(6'b000100)) dut (
        .clk(clk), .rst(rst),
        .reg_addr_i(reg_addr), .write_i(write), .new_req_i(new_req),
        .write_value_i(write_value), .read_value_o(read_value),
        .in_transaction_i(in_transaction), .tx_arr_i(tx_arr),
        .rx_arr_o(rx_arr), .rx_wr_mask_o(rx_wr_mask),
        .new_rx_o(new_rx), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle request; the registered response is visible on return.
    task automatic req(input logic wr, input logic [2:0] a, input logic [7:0] d);
        new_req = 1'b1; write = wr; reg_addr = a; write_value = d;
        tick();
        new_req = 1'b0; write = 1'b0;
    endtask

    initial begin
        // reset
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_read_value", 48'(read_value), 48'h0);
        chk("rst_rx_arr", rx_arr, 48'h0);
        chk("rst_mask", 48'(rx_wr_mask), 48'h0);
        chk("rst_new_rx", 48'(new_rx), 48'h0);
        chk("rst_busy", 48'(busy), 48'h0);
        chk("rst_err", 48'(err), 48'h0);

        // atomic commit + snapshot coherence
        in_transaction = 1'b1;
        tick();
        chk("t1_busy_open", 48'(busy), 48'h1);
        req(1'b1, 3'd1, 8'hA5);
        chk("t1_rx_unchanged_a", rx_arr, 48'h0);
        chk("t1_err_ok", 48'(err), 48'h0);
        req(1'b1, 3'd4, 8'h3C);
        chk("t1_rx_unchanged_b", rx_arr, 48'h0);
        tx_arr[7:0] = 8'h22;
        req(1'b0, 3'd0, 8'h00);
        chk("t2_snapshot_read", 48'(read_value), 48'h11);
        in_transaction = 1'b0;
        tick();
        chk("t1_commit_busy", 48'(busy), 48'h1);
        chk("t1_commit_rx_old", rx_arr, 48'h0);
        chk("t1_commit_new_rx_lo", 48'(new_rx), 48'h0);
        tick();
        chk("t1_rx_arr", rx_arr, 48'h003C0000A500);
        chk("t1_mask", 48'(rx_wr_mask), 48'h12);
        chk("t1_new_rx", 48'(new_rx), 48'h1);
        chk("t1_busy_done", 48'(busy), 48'h0);
        tick();
        chk("t1_new_rx_once", 48'(new_rx), 48'h0);

        // next txn: read on the CS-rise cycle sees live tx_arr; RO/range errors
        in_transaction = 1'b1;
        req(1'b0, 3'd0, 8'h00);
        chk("t2_live_read", 48'(read_value), 48'h22);
        chk("t2_err_none", 48'(err), 48'h0);
        req(1'b1, 3'd2, 8'h77);
        chk("t3_ro_err", 48'(err), 48'h1);
        tick();
        chk("t3_err_pulse", 48'(err), 48'h0);
        req(1'b0, 3'd7, 8'h00);
        chk("t3_oor_read", 48'(read_value), 48'h0);
        chk("t3_oor_read_err", 48'(err), 48'h1);
        req(1'b1, 3'd7, 8'h55);
        chk("t3_oor_write_err", 48'(err), 48'h1);
        in_transaction = 1'b0;
        tick(); tick();
        chk("t3_no_new_rx", 48'(new_rx), 48'h0);
        chk("t3_rx_kept", rx_arr, 48'h003C0000A500);
        chk("t3_mask_kept", 48'(rx_wr_mask), 48'h12);

        // request while IDLE and CS low is ignored
        req(1'b0, 3'd1, 8'h00);
        chk("idle_req_hold", 48'(read_value), 48'h0);
        chk("idle_req_no_err", 48'(err), 48'h0);

        // read-only transaction
        in_transaction = 1'b1;
        tick();
        req(1'b0, 3'd3, 8'h00);
        chk("t4_read", 48'(read_value), 48'h40);
        tick();
        chk("t4_read_hold", 48'(read_value), 48'h40);
        in_transaction = 1'b0;
        tick();
        chk("t4_no_new_rx_a", 48'(new_rx), 48'h0);
        tick();
        chk("t4_no_new_rx_b", 48'(new_rx), 48'h0);
        chk("t4_mask_kept", 48'(rx_wr_mask), 48'h12);
        chk("t4_busy", 48'(busy), 48'h0);

        // last write wins
        in_transaction = 1'b1;
        tick();
        req(1'b1, 3'd3, 8'h01);
        req(1'b1, 3'd3, 8'h02);
        in_transaction = 1'b0;
        tick(); tick();
        chk("t5_rx_arr", rx_arr, 48'h003C0200A500);
        chk("t5_mask", 48'(rx_wr_mask), 48'h08);
        chk("t5_new_rx", 48'(new_rx), 48'h1);
        tick();
        chk("t5_new_rx_once", 48'(new_rx), 48'h0);

        // reset mid-transaction
        in_transaction = 1'b1;
        tick();
        req(1'b1, 3'd5, 8'hFF);
        rst = 1'b1;
        tick();
        chk("t6_rst_rx", rx_arr, 48'h0);
        chk("t6_rst_busy", 48'(busy), 48'h0);
        in_transaction = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6_rx_arr", rx_arr, 48'h0);
        chk("t6_new_rx", 48'(new_rx), 48'h0);
        chk("t6_busy", 48'(busy), 48'h0);
        chk("t6_mask", 48'(rx_wr_mask), 48'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_regfile_bridge.md
Name: spi_regfile_bridge

Overview:
Parametrised register-file bridge between the SPI slave address/data front end and fabric logic. It gives transaction-atomic register semantics, which the earlier com-logic lacked.
- All writes in one SPI transaction are staged and committed to rx_arr together on transaction end.
- All reads in one transaction come from a tx_arr snapshot taken at transaction start.
- Adds per-register read-only protection, out-of-range address handling, a per-register written mask and an error pulse.

Parameters:
ADDR_SPACE, 256, number of registers (need not be a power of two, >=1)
WORD_SIZE, 8, bits per register
RO_MASK, {ADDR_SPACE{1'b0}}, bit i=1 makes register i read-only from SPI (writes dropped)
AW (localparam), max(1,$clog2(ADDR_SPACE)), address width

Ports:
clk  in  1  clock
rst  in  1  reset
reg_addr  in  AW  register address of current request
write  in  1  request is a write (qualified by new_req)
new_req  in  1  one-cycle request strobe
write_value  in  WORD_SIZE  write data
read_value  out  WORD_SIZE  read data, valid 1 cycle after new_req
in_transaction  in  1  high for the duration of an SPI transaction (CS asserted)
tx_arr  in  WORD_SIZE*ADDR_SPACE  live fabric-to-host registers
rx_arr  out  WORD_SIZE*ADDR_SPACE  committed host-to-fabric registers
rx_wr_mask  out  ADDR_SPACE  registers written by the last committed transaction
new_rx  out  1  one-cycle pulse when rx_arr updates
busy  out  1  high while a transaction is open or committing
err  out  1  one-cycle pulse: write to RO register, or any access with reg_addr>=ADDR_SPACE

Behaviour:
- Reset (synchronous, active-high rst; clock clk): read_value=0, rx_arr=0, rx_wr_mask=0, new_rx=0, busy=0, err=0. Staging is discarded and FSM goes to IDLE.
- FSM states: IDLE, ACTIVE, COMMIT.
- IDLE -> ACTIVE when in_transaction=1. On that cycle:
  - snapshot <= tx_arr;
  - staging <= rx_arr;
  - stage_mask <= 0.
- ACTIVE:
  - new_req read: read_value <= snapshot[addr] on the next edge. When new_req coincides with the IDLE->ACTIVE cycle, read the live tx_arr instead.
  - new_req && write: staging[addr] <= write_value and stage_mask[addr] <= 1, unless the register is RO or out of range.
  - Repeated writes to one address: last write wins.
  - A read never returns staged data; tx and rx spaces are independent.
- ACTIVE -> COMMIT when in_transaction=0.
- COMMIT lasts one cycle, then -> IDLE.
  - If stage_mask!=0: rx_arr <= staging, rx_wr_mask <= stage_mask, new_rx=1 for exactly that cycle.
  - If stage_mask==0: rx_arr and rx_wr_mask are unchanged and new_rx=0. A read-only transaction produces no pulse.
- rx_arr changes only in COMMIT. Fabric never sees a partial transaction.
- busy=1 in ACTIVE and COMMIT, and in the IDLE cycle where in_transaction rises (registered, so it asserts one cycle later).
- in_transaction re-asserting during COMMIT is held until the next IDLE cycle. Front-end CS deassert spacing is >=2 clk.
- new_req while IDLE with in_transaction=0: ignored. read_value holds, no err.
- Out of range (reg_addr>=ADDR_SPACE): read_value <= 0, write dropped, err pulses 1 cycle after new_req. An RO write also pulses err.
- read_value holds its last value between requests.
- Reset mid-transaction: staged writes are discarded and rx_arr is cleared. The subsequent CS deassert produces no commit.

Decomposition:
- Shared package spi_regs_pkg holds:
  - FSM state enum (IDLE/ACTIVE/COMMIT);
  - function addr_valid(addr, ADDR_SPACE);
  - default WORD_SIZE constant.
- One natural sub-module: spi_reg_bank, a parametrised WORD_SIZE x ADDR_SPACE array with per-entry write enable and load-all port. It is instantiated twice: staging and snapshot.
- FSM and error logic stay in the top module.

Test Plan (ADDR_SPACE=6, WORD_SIZE=8, RO_MASK=6'b000100):
- Atomic commit: open txn, write A5 to reg1 and 3C to reg4; rx_arr unchanged until CS falls -> one cycle later rx_arr[1]=A5, rx_arr[4]=3C, rx_wr_mask=6'b010010, new_rx pulses exactly 1 cycle.
- Snapshot coherence: tx_arr[0]=11 at txn start; change tx_arr[0]=22 mid-txn; read reg0 -> read_value=11. Next txn read -> 22.
- RO/range: write 77 to reg2 -> err pulse, rx_arr[2] stays 00. Read reg7 -> read_value=00, err pulse. Write 55 to reg7 -> dropped, err pulse.
- Read-only txn: txn with reads only -> new_rx never asserts, rx_wr_mask keeps previous value.
- Last-write-wins: write 01 then 02 to reg3 in one txn -> rx_arr[3]=02 after commit, single new_rx.
- Reset mid-txn: write FF to reg5, assert rst, then drop CS -> rx_arr all 0, new_rx stays 0, busy 0.
